cla_seq_adder_ctrl: RTL and testbench

- Multi-precision adder controller that reuses a single 4-bit carry-lookahead slice (`cla`) to add WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Sits between a requester with a start/ready handshake and the shared 4-bit CLA datapath.
- Sequences operand nibbles into the slice, registers the inter-nibble carry, and assembles the full sum and carry-out.

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_seq_adder_ctrl_if.sv | 30 +++
 rtl/cla.sv | 32 +++
 rtl/cla_seq_adder_ctrl.sv | 115 +++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and constants for the sequential CLA adder
// Purpose : FSM state encoding and slice width shared by the controller
//           and its testbench.
// Ports   : none (package).
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// rtl/cla_seq_adder_ctrl_if.sv - request/result bundle of the sequential adder
// Purpose : groups the start/ready handshake, operands and result signals.
// Ports   : none; signals start, a, b, cin (requester -> adder) and
//           ready, busy, done, sum, cout (adder -> requester).
//           master = requester side, slave = adder side.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/cla.sv
// rtl/cla.sv - 4-bit carry-lookahead adder slice
// Purpose : combinational nibble adder with lookahead carries.
// Ports   : a, b (4-bit operands), cin (carry-in),
//           sum (4-bit result), cout (carry-out).
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from cin so no carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - WIDTH-bit adder built from one reused CLA nibble slice
// Purpose : accepts a request in IDLE, feeds one operand nibble per cycle
//           (LSB first) through a single 4-bit CLA slice, then presents the
//           full sum and carry-out with a one-cycle done pulse.
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           bus   - slave side of cla_seq_adder_ctrl_if (start/ready
//                   handshake, a/b/cin operands, busy/done/sum/cout results)
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  cla_seq_adder_ctrl_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES) + 1;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] acc_d;
  logic             last_nibble;

  cla u_cla (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the MSB end; after NIBBLES passes the first
  // nibble has reached bit 0. Written with shifts so WIDTH=4 stays legal.
  assign slice_ext   = WIDTH'(slice_sum);
  assign acc_d       = (acc_q >> NIBBLE_W) | (slice_ext << (WIDTH - NIBBLE_W));
  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIBBLE_W;
          b_sh_q  <= b_sh_q >> NIBBLE_W;
          carry_q <= slice_cout;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_nibble) begin
            sum_q   <= acc_d;
            cout_q  <= slice_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - self-checking bench for cla_seq_adder_ctrl
module tb_cla_seq_adder_ctrl;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  cla_seq_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  cla_seq_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  cla_seq_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  cla_seq_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec16_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_cout;
  } vec4_t;

  logic [15:0] hold_sum16;
  logic        hold_cout16;
  logic [3:0]  hold_sum4;
  logic        hold_cout4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for done on the 16-bit DUT; every non-done cycle the previous
  // result must still be held and the handshake must stay closed.
  task automatic wait_done16(input string name, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus16.done === 1'b1) break;
      chk({name, " hold_sum"}, 32'(bus16.sum), 32'(hold_sum16));
      chk({name, " ready_low"}, 32'(bus16.ready), 32'd0);
    end
    if (lat >= 20) chk({name, " done_timeout"}, 32'(lat), 32'd4);
  endtask

  task automatic run16(input string name, input vec16_t v);
    int lat;
    chk({name, " ready_idle"}, 32'(bus16.ready), 32'd1);
    bus16.a     = v.a;
    bus16.b     = v.b;
    bus16.cin   = v.cin;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = ~v.a;
    bus16.b     = ~v.b;
    chk({name, " busy"}, 32'(bus16.busy), 32'd1);
    wait_done16(name, lat);
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " sum"}, 32'(bus16.sum), 32'(v.exp_sum));
    chk({name, " cout"}, 32'(bus16.cout), 32'(v.exp_cout));
    hold_sum16  = v.exp_sum;
    hold_cout16 = v.exp_cout;
    @(posedge clk);
    @(negedge clk);
    chk({name, " done_one_cycle"}, 32'(bus16.done), 32'd0);
    chk({name, " busy_clear"}, 32'(bus16.busy), 32'd0);
  endtask

  task automatic run4(input string name, input vec4_t v);
    int lat;
    chk({name, " ready_idle"}, 32'(bus4.ready), 32'd1);
    bus4.a     = v.a;
    bus4.b     = v.b;
    bus4.cin   = v.cin;
    bus4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus4.done === 1'b1) break;
    end
    chk({name, " latency"}, 32'(lat), 32'd1);
    chk({name, " sum"}, 32'(bus4.sum), 32'(v.exp_sum));
    chk({name, " cout"}, 32'(bus4.cout), 32'(v.exp_cout));
    hold_sum4  = v.exp_sum;
    hold_cout4 = v.exp_cout;
    @(posedge clk);
    @(negedge clk);
    chk({name, " done_one_cycle"}, 32'(bus4.done), 32'd0);
  endtask

  vec16_t tbl16 [7];
  vec4_t  tbl4  [2];

  initial begin
    int lat;
    total = 0;
    bad   = 0;

    tbl16[0] = '{16'h0001, 16'h0006, 1'b0, 16'h0007, 1'b0};
    tbl16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl16[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl16[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    tbl16[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl16[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl16[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    tbl4[0]  = '{4'h9, 4'h3, 1'b1, 4'hD, 1'b0};
    tbl4[1]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};

    rst_n       = 1'b0;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    bus16.cin   = 1'b0;
    bus4.start  = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;
    bus4.cin    = 1'b0;
    hold_sum16  = '0;
    hold_cout16 = 1'b0;
    hold_sum4   = '0;
    hold_cout4  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset ready", 32'(bus16.ready), 32'd1);
    chk("reset busy", 32'(bus16.busy), 32'd0);
    chk("reset done", 32'(bus16.done), 32'd0);
    chk("reset sum", 32'(bus16.sum), 32'd0);
    chk("reset cout", 32'(bus16.cout), 32'd0);
    chk("reset4 ready", 32'(bus4.ready), 32'd1);
    chk("reset4 sum", 32'(bus4.sum), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run16($sformatf("vec16[%0d]", i), tbl16[i]);
    end

    // start held high with changing operands while the adder is busy
    bus16.a     = 16'h00FF;
    bus16.b     = 16'h0001;
    bus16.cin   = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.a = 16'h1111;
    bus16.b = 16'h2222;
    chk("hold first accept", 32'(bus16.ready), 32'd0);
    wait_done16("hold op1", lat);
    chk("hold op1 latency", 32'(lat), 32'd4);
    chk("hold op1 sum", 32'(bus16.sum), 32'h0100);
    chk("hold op1 cout", 32'(bus16.cout), 32'd0);
    hold_sum16 = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    chk("hold idle ready", 32'(bus16.ready), 32'd1);
    chk("hold idle sum", 32'(bus16.sum), 32'h0100);
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    chk("hold second accept", 32'(bus16.ready), 32'd0);
    wait_done16("hold op2", lat);
    chk("hold op2 latency", 32'(lat), 32'd4);
    chk("hold op2 sum", 32'(bus16.sum), 32'h3333);
    chk("hold op2 cout", 32'(bus16.cout), 32'd0);
    hold_sum16 = 16'h3333;
    @(posedge clk);
    @(negedge clk);

    // reset during the second RUN cycle abandons the operation
    bus16.a     = 16'h0F0F;
    bus16.b     = 16'h0101;
    bus16.cin   = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun reset ready", 32'(bus16.ready), 32'd1);
    chk("midrun reset busy", 32'(bus16.busy), 32'd0);
    chk("midrun reset done", 32'(bus16.done), 32'd0);
    chk("midrun reset sum", 32'(bus16.sum), 32'd0);
    chk("midrun reset cout", 32'(bus16.cout), 32'd0);
    hold_sum16  = '0;
    hold_cout16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrun no done", 32'(bus16.done), 32'd0);
    end
    run16("after reset", '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0});

    for (int i = 0; i < 2; i++) begin
      run4($sformatf("vec4[%0d]", i), tbl4[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
